// File: rtl/jcr_prog_loader.sv
// jcr_prog_loader -- UART program loader for the Jacaranda-8 core.
//
// Receives 8N1 frames on rx and writes the payload into the 256x8
// instruction memory. The CPU is held in reset until a frame with a good
// checksum has been written.
// Frame layout: SYNC_BYTE, LEN (0 = 256), LEN payload bytes, CHK (8-bit sum).
//
// Ports:
//   wb_clk_i   in   system clock
//   wb_rst_i   in   asynchronous active-high reset
//   rx         in   UART serial input, idle high, asynchronous to wb_clk_i
//   imem_we    out  single-cycle instruction-memory write strobe
//   imem_addr  out  [7:0] write address
//   imem_wdata out  [7:0] write data
//   cpu_rst    out  1 = CPU held in reset
//   load_done  out  level, set after a verified load
//   load_err   out  level, set after an aborted or failed load
module jcr_prog_loader #(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       rx,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_rst,
  output logic       load_done,
  output logic       load_err
);

  // Counter compare points: a count of N-1 marks the Nth cycle in a phase.
  localparam logic [15:0] C_FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} ld_state_t;

  // ---------------- RX front end ----------------
  logic        r_rx_meta;
  logic        r_rx_sync;
  logic        r_rx_prev;
  rx_state_t   r_rx_st;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_byte;
  logic        r_rx_valid;
  logic        r_rx_ferr;
  logic        w_fall;

  assign w_fall = r_rx_prev & ~r_rx_sync;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // Synchronizer resets to the idle line level so release is not a start.
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_st)
        RX_IDLE: begin
          if (w_fall) begin
            r_rx_st <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            r_bit <= '0;
            // Line back high at mid start bit: a glitch, not a character.
            r_rx_st <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};  // LSB arrives first
            if (r_bit == 3'd7) r_rx_st <= RX_STOP;
            r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (r_cnt == C_FULL) begin
            r_cnt   <= '0;
            r_rx_st <= RX_IDLE;
            if (r_rx_sync) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_shift;
            end else begin
              r_rx_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- Frame loader ----------------
  ld_state_t  r_st;
  logic [8:0] r_left;   // payload bytes still expected (up to 256)
  logic [7:0] r_addr;
  logic [7:0] r_sum;
  logic       r_we;
  logic [7:0] r_waddr;
  logic [7:0] r_wdata;
  logic       r_cpu_rst;
  logic       r_done;
  logic       r_err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_st      <= S_IDLE;
      r_left    <= '0;
      r_addr    <= '0;
      r_sum     <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_rx_ferr) begin
        // A broken character inside a frame aborts it; outside a frame it is noise.
        if (r_st == S_LEN || r_st == S_DATA || r_st == S_CHK) begin
          r_st      <= S_IDLE;
          r_err     <= 1'b1;
          r_cpu_rst <= 1'b1;
        end
      end else if (r_rx_valid) begin
        case (r_st)
          S_IDLE, S_DONE: begin
            if (r_rx_byte == SYNC_BYTE) begin
              r_st      <= S_LEN;
              r_cpu_rst <= 1'b1;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_addr    <= '0;
              r_sum     <= '0;
            end
          end
          S_LEN: begin
            r_left <= (r_rx_byte == 8'd0) ? 9'd256 : {1'b0, r_rx_byte};
            r_st   <= S_DATA;
          end
          S_DATA: begin
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= r_rx_byte;
            r_sum   <= r_sum + r_rx_byte;
            r_addr  <= r_addr + 8'd1;
            r_left  <= r_left - 9'd1;
            if (r_left == 9'd1) r_st <= S_CHK;
          end
          S_CHK: begin
            if (r_rx_byte == r_sum) begin
              r_st      <= S_DONE;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_st  <= S_IDLE;
              r_err <= 1'b1;
            end
          end
          default: r_st <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign cpu_rst    = r_cpu_rst;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule
